// File: rtl/conv3_xnor_pop.sv
// Binarised 3-tap 1-D convolution: XNOR-popcount against per-channel weights,
// thresholded to one bit per output channel, with zero-padding at image edges.
module conv3_xnor_pop #(
    parameter  int NO_CH         = 8,
    parameter  int NO_OUT        = 8,
    parameter  int LOG2_IMG_SIZE = 7,
    parameter  int THROUGHPUT    = 1,
    localparam int TW            = $clog2(3*NO_CH+1),
    localparam int WORDS         = (2**LOG2_IMG_SIZE) / THROUGHPUT,
    localparam int AW            = (NO_OUT > 1) ? $clog2(NO_OUT) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   vld_in,
    input  logic [THROUGHPUT+1:0][NO_CH-1:0]       data_in,
    input  logic                                   wgt_we,
    input  logic [AW-1:0]                          wgt_addr,
    input  logic [3*NO_CH-1:0]                     wgt_data,
    input  logic [TW-1:0]                          thr_data,
    output logic                                   vld_out,
    output logic [THROUGHPUT-1:0][NO_OUT-1:0]      data_out
);

    localparam int CW = (LOG2_IMG_SIZE - $clog2(THROUGHPUT) > 0) ?
                        (LOG2_IMG_SIZE - $clog2(THROUGHPUT)) : 1;
    localparam int PW = $clog2(NO_CH+1);
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS-1);
    localparam logic [AW:0]   ADDR_LIM  = (AW+1)'(NO_OUT);

    function automatic logic [PW-1:0] pop_xnor(input logic [NO_CH-1:0] a,
                                               input logic [NO_CH-1:0] w);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < NO_CH; i++) begin
            n = n + PW'(~(a[i] ^ w[i]));
        end
        return n;
    endfunction

    logic [3*NO_CH-1:0] w_q   [NO_OUT];
    logic [3*NO_CH-1:0] w_d   [NO_OUT];
    logic [TW-1:0]      thr_q [NO_OUT];
    logic [TW-1:0]      thr_d [NO_OUT];
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [PW-1:0]      pop_p1_q [THROUGHPUT][NO_OUT][3];
    logic [PW-1:0]      pop_p1_d [THROUGHPUT][NO_OUT][3];
    logic [TW-1:0]      thr_p1_q [NO_OUT];
    logic [TW-1:0]      thr_p1_d [NO_OUT];
    logic               mask_l_p1_q, mask_l_p1_d;
    logic               mask_r_p1_q, mask_r_p1_d;
    logic               vld_p1_q, vld_p1_d;

    logic [THROUGHPUT-1:0][NO_OUT-1:0] data_out_q, data_out_d;
    logic               vld_p2_q, vld_p2_d;
    logic [TW-1:0]      score_p2;

    // Weight/threshold store and position counter
    always_comb begin
        w_d   = w_q;
        thr_d = thr_q;
        if (wgt_we && ({1'b0, wgt_addr} < ADDR_LIM)) begin
            w_d[wgt_addr]   = wgt_data;
            thr_d[wgt_addr] = thr_data;
        end
        cnt_d = cnt_q;
        if (vld_in) begin
            cnt_d = (cnt_q == LAST_WORD) ? '0 : cnt_q + CW'(1);
        end
    end

    // Stage 1: per-tap popcounts, edge masks and the thresholds in force
    // when the word was accepted, so a concurrent write never splits a word.
    always_comb begin
        for (int k = 0; k < THROUGHPUT; k++) begin
            for (int o = 0; o < NO_OUT; o++) begin
                for (int t = 0; t < 3; t++) begin
                    pop_p1_d[k][o][t] = pop_xnor(data_in[k+2-t],
                                                 w_q[o][(2-t)*NO_CH +: NO_CH]);
                end
            end
        end
        thr_p1_d    = thr_q;
        mask_l_p1_d = (cnt_q == '0);
        mask_r_p1_d = (cnt_q == LAST_WORD);
        vld_p1_d    = vld_in;
    end

    // Stage 2: masked sum and threshold compare
    always_comb begin
        score_p2   = '0;
        data_out_d = data_out_q;
        vld_p2_d   = vld_p1_q;
        if (vld_p1_q) begin
            for (int k = 0; k < THROUGHPUT; k++) begin
                for (int o = 0; o < NO_OUT; o++) begin
                    score_p2 = TW'(pop_p1_q[k][o][1]);
                    if (!(k == 0 && mask_l_p1_q)) begin
                        score_p2 = score_p2 + TW'(pop_p1_q[k][o][0]);
                    end
                    if (!(k == THROUGHPUT-1 && mask_r_p1_q)) begin
                        score_p2 = score_p2 + TW'(pop_p1_q[k][o][2]);
                    end
                    data_out_d[k][o] = (score_p2 >= thr_p1_q[o]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            data_out_q <= '0;
            for (int o = 0; o < NO_OUT; o++) begin
                w_q[o]   <= '0;
                thr_q[o] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            data_out_q <= data_out_d;
            w_q        <= w_d;
            thr_q      <= thr_d;
        end
    end

    always_ff @(posedge clk) begin
        pop_p1_q    <= pop_p1_d;
        thr_p1_q    <= thr_p1_d;
        mask_l_p1_q <= mask_l_p1_d;
        mask_r_p1_q <= mask_r_p1_d;
    end

    assign vld_out  = vld_p2_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_conv3_xnor_pop.sv
// Scoreboard bench for conv3_xnor_pop: stimulus queues hand-derived results,
// an independent negedge monitor pops and compares them against the outputs.
module tb_conv3_xnor_pop;

    localparam int IMG = 128;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            vld_in = 1'b0;
    logic [2:0][7:0] data_in = '0;
    logic            wgt_we = 1'b0;
    logic [2:0]      wgt_addr = '0;
    logic [23:0]     wgt_data = '0;
    logic [4:0]      thr_data = '0;
    logic            vld_out;
    logic [0:0][7:0] data_out;

    conv3_xnor_pop #(
        .NO_CH(8), .NO_OUT(8), .LOG2_IMG_SIZE(7), .THROUGHPUT(1)
    ) dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .thr_data(thr_data), .vld_out(vld_out), .data_out(data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         due;
        int         pos;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   checks = 0;
    int   errors = 0;
    int   pos = 0;
    logic [7:0] prev_do = '0;
    bit   prev_rst = 1'b1;

    always @(negedge clk) begin
        if (vld_out) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious_vld_out data %02h at cycle %0d", data_out[0], cyc);
            end else begin
                e_m = q.pop_front();
                if (data_out[0] !== e_m.d || cyc != e_m.due) begin
                    errors++;
                    $display("FAIL out_pos%0d got %02h at cycle %0d, want %02h at cycle %0d",
                             e_m.pos, data_out[0], cyc, e_m.d, e_m.due);
                end
            end
        end else if (!rst && !prev_rst) begin
            checks++;
            if (data_out[0] !== prev_do) begin
                errors++;
                $display("FAIL hold_data_out got %02h want %02h at cycle %0d",
                         data_out[0], prev_do, cyc);
            end
        end
        prev_do  = data_out[0];
        prev_rst = rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        vld_in = 1'b1;
        data_in = 24'($urandom());
        @(posedge clk);
        #1;
        q.delete();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk("rst_vld_out", 32'(vld_out), 32'd0);
            chk("rst_data_out", 32'(data_out[0]), 32'd0);
            @(posedge clk);
            #1;
            vld_in = ~vld_in;
            data_in = 24'($urandom());
        end
        rst = 1'b0;
        vld_in = 1'b0;
        pos = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_vld_out", 32'(vld_out), 32'd0);
            chk("post_rst_data_out", 32'(data_out[0]), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_all(input logic [23:0] w_all, input int hot,
                            input logic [23:0] w_hot, input logic [4:0] thr);
        for (int o = 0; o < 8; o++) begin
            wgt_we   = 1'b1;
            wgt_addr = 3'(o);
            wgt_data = (o == hot) ? w_hot : w_all;
            thr_data = thr;
            @(posedge clk);
            #1;
        end
        wgt_we = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d, input logic [7:0] int_v,
                        input logic [7:0] edge_v, input int gap_max);
        int gaps;
        exp_t e;
        gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        for (int g = 0; g < gaps; g++) begin
            vld_in  = 1'b0;
            data_in = 24'($urandom());
            @(posedge clk);
            #1;
        end
        vld_in  = 1'b1;
        data_in = {d, d, d};
        e.d   = (pos == 0 || pos == IMG-1) ? edge_v : int_v;
        e.due = cyc + 2;
        e.pos = pos;
        q.push_back(e);
        pos = (pos + 1) % IMG;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        do_reset(5);

        // all-zero weights and data: interior score 24, edge score 16
        load_all(24'h0, -1, 24'h0, 5'd24);
        for (int i = 0; i < IMG; i++) feed(8'h00, 8'hFF, 8'h00, 0);

        load_all(24'h0, -1, 24'h0, 5'd16);
        for (int i = 0; i < IMG; i++) feed(8'h00, 8'hFF, 8'hFF, 0);

        load_all(24'h0, 3, 24'hFFFFFF, 5'd24);
        for (int i = 0; i < IMG; i++) feed(8'hFF, 8'h08, 8'h00, 0);

        // idle gaps between words must not move the position counter
        load_all(24'h0, -1, 24'h0, 5'd24);
        for (int i = 0; i < IMG; i++) feed(8'h00, 8'hFF, 8'h00, 3);

        // threshold write on the same edge as word 1: word 1 sees old, word 2 new
        feed(8'h00, 8'hFF, 8'h00, 0);
        vld_in   = 1'b1;
        data_in  = '0;
        wgt_we   = 1'b1;
        wgt_addr = 3'd5;
        wgt_data = 24'h0;
        thr_data = 5'd25;
        e.d = 8'hFF; e.due = cyc + 2; e.pos = pos;
        q.push_back(e);
        pos = pos + 1;
        @(posedge clk);
        #1;
        wgt_we = 1'b0;
        feed(8'h00, 8'hDF, 8'h00, 0);
        load_all(24'h0, -1, 24'h0, 5'd24);
        for (int i = 3; i < IMG; i++) feed(8'h00, 8'hFF, 8'h00, 0);

        // reset mid-image, then restart at position 0
        for (int i = 0; i < 50; i++) feed(8'h00, 8'hFF, 8'h00, 0);
        do_reset(3);
        load_all(24'h0, -1, 24'h0, 5'd24);
        for (int i = 0; i < IMG + 2; i++) feed(8'h00, 8'hFF, 8'h00, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain outstanding %0d want 0", q.size());
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
